// File: rtl/latch_stage_skid.sv
// Handshaked pipeline-stage register with a 2-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter. The ready signal never depends on out_ready.
module latch_stage_skid #(
    parameter int DATA_WIDTH  = 38,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    // Valid/ready: a word moves on an edge where both valid and ready are high;
    // valid must not drop and data must not change until that edge happens.

    logic                   r_main_valid;
    logic [DATA_WIDTH-1:0]  r_main_data;
    logic                   r_skid_valid;
    logic [DATA_WIDTH-1:0]  r_skid_data;
    logic [COUNT_WIDTH-1:0] r_stall_count;

    logic w_in_ready;
    logic w_in_fire;
    logic w_main_free;
    logic w_stalled;

    assign w_in_ready  = !r_skid_valid && !flush;
    assign w_in_fire   = in_valid && w_in_ready;
    assign w_main_free = !r_main_valid || out_ready;
    assign w_stalled   = r_main_valid && !out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_main_valid  <= 1'b0;
            r_main_data   <= '0;
            r_skid_valid  <= 1'b0;
            r_skid_data   <= '0;
            r_stall_count <= '0;
        end else begin
            if (flush) begin
                r_main_valid <= 1'b0;
                r_main_data  <= '0;
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
            end else if (w_main_free) begin
                // The skid word is older than anything upstream, so it drains first.
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                    r_skid_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= in_data;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= in_data;
            end

            if (!flush && w_stalled && (r_stall_count != {COUNT_WIDTH{1'b1}})) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_main_valid;
    assign out_data    = r_main_data;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_latch_stage_skid.sv
// Directed bench for latch_stage_skid: reset, streaming, skid back-pressure, flush,
// stall counter saturation (4-bit counter) and reset in the middle of a transfer.
module tb_latch_stage_skid;

    localparam int DW = 38;
    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    latch_stage_skid #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stall_count (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 38'h12345678AB;
        out_ready = 1'b0;

        // Reset held for two cycles with a word offered upstream
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_out_data", 64'(out_data), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd1);
            check("rst_stall", 64'(stall_count), 64'd0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        step();
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // Streaming with out_ready high: one word per cycle, one cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DW'(i);
            step();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_data", 64'(out_data), 64'(i));
            check("stream_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", 64'(out_valid), 64'd0);
        check("stream_stall", 64'(stall_count), 64'd0);

        // Back-pressure fills main then skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 38'hA1;
        step();
        check("skid_a1_data", 64'(out_data), 64'hA1);
        check("skid_a1_ready", 64'(in_ready), 64'd1);
        in_data = 38'hA2;
        step();
        check("skid_full_ready", 64'(in_ready), 64'd0);
        check("skid_full_data", 64'(out_data), 64'hA1);
        check("skid_full_valid", 64'(out_valid), 64'd1);
        check("skid_stall", 64'(stall_count), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("skid_a2_data", 64'(out_data), 64'hA2);
        check("skid_a2_valid", 64'(out_valid), 64'd1);
        check("skid_a2_ready", 64'(in_ready), 64'd1);
        step();
        check("skid_empty_valid", 64'(out_valid), 64'd0);

        // Flush with both entries occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 38'hB1;
        step();
        in_data = 38'hB2;
        step();
        check("flush_full_ready", 64'(in_ready), 64'd0);
        check("flush_pre_stall", 64'(stall_count), 64'd2);
        flush   = 1'b1;
        in_data = 38'hB3;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_data", 64'(out_data), 64'd0);
        check("flush_ready_back", 64'(in_ready), 64'd1);
        check("flush_stall_kept", 64'(stall_count), 64'd2);
        step();
        check("b3_valid", 64'(out_valid), 64'd1);
        check("b3_data", 64'(out_data), 64'hB3);

        // Stall counter saturates at 15 with a 4-bit counter
        in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("stall_sat", 64'(stall_count), (2 + k > 15) ? 64'd15 : 64'(2 + k));
        end
        check("stall_hold_valid", 64'(out_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("stall_after_flush", 64'(stall_count), 64'd15);
        check("stall_flush_valid", 64'(out_valid), 64'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("stall_after_reset", 64'(stall_count), 64'd0);

        // Reset in the middle of a transfer with two words held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 38'hC1;
        step();
        in_data = 38'hC2;
        step();
        check("mid_full_ready", 64'(in_ready), 64'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd1);
        check("mid_rst_stall", 64'(stall_count), 64'd0);
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 38'h3F_0000_00D1;
        out_ready = 1'b1;
        step();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_data", 64'(out_data), 64'h3F_0000_00D1);
        in_valid = 1'b0;
        step();
        check("post_rst_drain", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/latch_stage_skid.md
Name: latch_stage_skid

Overview:
- Parametrised, handshaked pipeline-stage register for inter-stage latches such as IF/ID, ID/EX, EX/MEM and MEM/WB.
- Replaces fixed-field, always-passing latches with a generic DATA_WIDTH payload, a valid/ready handshake and a 2-entry skid buffer, so back-pressure never needs a combinational ready path.
- Adds synchronous flush for branch and exception squash, plus a saturating stall-cycle counter for performance monitoring.

Parameters:
- DATA_WIDTH, 38, payload width in bits (default is write-enable 1 + address 5 + data 32).
- COUNT_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream presents a word.
- in_ready  output  1  stage can accept a word this cycle.
- in_data  input  DATA_WIDTH  upstream payload.
- out_valid  output  1  stage presents a word downstream.
- out_ready  input  1  downstream accepts the word.
- out_data  output  DATA_WIDTH  downstream payload.
- stall_count  output  COUNT_WIDTH  saturating count of back-pressured cycles.

Behaviour:
- State:
  - main entry (main_valid, main_data) drives out_valid and out_data directly.
  - skid entry (skid_valid, skid_data) holds overflow.
- Handshake definitions:
  - in_fire = in_valid && in_ready.
  - out_fire = out_valid && out_ready.
- in_ready = !skid_valid && !flush. It has no path from out_ready.
- Reset (priority over everything), at the next edge:
  - main_valid = 0, skid_valid = 0, main_data = 0, skid_data = 0, stall_count = 0.
  - After reset: out_valid = 0, out_data = 0, in_ready = 1.
- Flush (when not in reset), at the next edge:
  - main_valid = 0, skid_valid = 0, main_data = 0, skid_data = 0.
  - in_ready is low during the flush cycle, so no word is accepted and none is silently dropped.
  - A pending out_fire in the flush cycle still counts as delivered downstream.
  - stall_count is not cleared by flush.
- Normal update, when main is free (main_valid = 0 or out_fire):
  - if skid_valid: main <= skid and skid_valid <= 0. in_fire cannot occur in this case.
  - else if in_fire: main <= in_data and main_valid <= 1.
  - else: main_valid <= 0; main_data holds its last value.
- Normal update, when main is blocked (main_valid = 1 and !out_ready):
  - if in_fire: skid <= in_data and skid_valid <= 1.
  - main holds.
- Latency and throughput:
  - 1 cycle from in_fire to out_valid when the stage is empty.
  - Sustained 1 word per cycle when out_ready is held high.
- Ordering: strict FIFO. The skid word always leaves before any newer word.
- Capacity: 2 words.
  - Full state (main_valid = 1 and skid_valid = 1) forces in_ready = 0.
  - Overflow is impossible by construction.
- Simultaneous out_fire and in_fire with skid empty: main is replaced by in_data in the same edge. No bubble is inserted.
- Payload data is never modified. Bit widths pass through unchanged.
- stall_count:
  - Increments by 1 on each edge where out_valid && !out_ready and neither reset nor flush is asserted.
  - Saturates at 2^COUNT_WIDTH-1 with no wrap.
- Reset asserted mid-transfer: all held words are discarded, and the output is valid-low on the very next cycle.

Test Plan:
- Reset for 2 cycles with in_valid = 1 and in_data = 0x12345678AB -> out_valid = 0, out_data = 0, in_ready = 1, stall_count = 0 throughout.
- Stream 0x01, 0x02, 0x03, 0x04 on consecutive cycles with out_ready = 1 -> out_data equals 0x01..0x04 on the following cycles, one cycle after each accept, with no gaps; in_ready stays 1.
- Send 0xA1 then 0xA2 with out_ready = 0 -> after the second accept, in_ready = 0 and out_data = 0xA1; raise out_ready -> 0xA1 then 0xA2 emerge on consecutive cycles; in_ready returns to 1 the cycle after 0xA1 leaves.
- Fill both entries (0xB1, 0xB2), then assert flush for one cycle with in_valid = 1 and in_data = 0xB3 -> in_ready = 0 during flush; the next cycle out_valid = 0 and out_data = 0; 0xB3 is accepted only after flush deasserts.
- Build with COUNT_WIDTH = 4, hold out_valid = 1 and out_ready = 0 for 20 cycles -> stall_count reaches 15 and holds at 15; a subsequent flush leaves it at 15; reset clears it to 0.
- Assert reset mid-stream with 2 words held -> the next cycle out_valid = 0 and in_ready = 1; the first word after reset deasserts emerges one cycle after its accept.
